phys_reg_free_list: RTL and testbench
=====================================

PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUM_LOG 32, number of architectural registers; NUM_PHY 64, number of physical registers; FL_DEPTH 32 (NUM_PHY-NUM_LOG), free-list capacity.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 alloc_req  in  1  rename stage requests one free physical register this cycle.
REQ-006 alloc_gnt  out  1  grant, combinational; alloc_preg is consumed when high.
REQ-007 alloc_preg  out  6  physical register ID at list head.
REQ-008 rel_valid  in  1  commit returns one physical register to the list.
REQ-009 rel_preg  in  6  physical register ID being returned.
REQ-010 ckpt_save  in  1  branch renamed; snapshot the head pointer.
REQ-011 flush  in  1  mispredict; restore the head pointer from the snapshot.
REQ-012 ready  out  1  high in RUN state.
REQ-013 free_count  out  6  registered count of free entries, 0..32.
REQ-014 almost_empty  out  1  free_count <= 2; decode stall hint.
REQ-015 err_overflow  out  1  sticky; a release was dropped because the list was full.

Function
REQ-016 Storage SHALL be a 32-entry circular buffer of 6-bit IDs with 6-bit rd_ptr/wr_ptr; the index is ptr[4:0] and the count is (wr_ptr - rd_ptr) mod 64.
REQ-017 The FSM SHALL have states INIT and RUN; reset enters INIT with an init counter of 0.
REQ-018 In INIT, each cycle SHALL write entry[i] = 32+i and increment wr_ptr; after the i=31 write the FSM SHALL go to RUN, giving 32 cycles from reset release to ready=1.
REQ-019 In INIT, alloc_gnt SHALL be 0, and rel_valid, ckpt_save and flush SHALL be ignored.
REQ-020 In RUN, alloc_gnt SHALL = alloc_req & (count != 0) & ~flush.
REQ-021 alloc_preg SHALL = entry[rd_ptr] whenever count != 0, and 0 when count == 0.
REQ-022 On alloc_gnt, rd_ptr SHALL increment at the clock edge, giving zero-latency allocation.
REQ-023 In RUN, rel_valid with (count < 32) or a same-cycle alloc_gnt SHALL write rel_preg at wr_ptr and increment wr_ptr.
REQ-024 rel_valid with count == 32 and no same-cycle alloc_gnt SHALL drop the release and set err_overflow.
REQ-025 At count == 0 with alloc_req and rel_valid together, there SHALL be no bypass: alloc_gnt=0, the release is written, and the next-cycle count is 1.
REQ-026 ckpt_save SHALL store the next-cycle rd_ptr in ckpt_ptr (rd_ptr+1 if granted the same cycle, else rd_ptr).
REQ-027 flush SHALL set rd_ptr to ckpt_ptr, freeing every register allocated since the snapshot.
REQ-028 A release in the flush cycle SHALL still be written.
REQ-029 ckpt_save in the same cycle as flush SHALL be ignored; flush wins.
REQ-030 free_count SHALL be registered and equal the post-edge count; almost_empty SHALL derive from free_count.
REQ-031 The block SHALL hold a single checkpoint; a new ckpt_save overwrites the old one.

Reset
REQ-032 rst_n low SHALL immediately force: state INIT, rd_ptr=wr_ptr=ckpt_ptr=0, init counter 0, free_count=0, ready=0, alloc_gnt=0, err_overflow=0, almost_empty=1.
REQ-033 Entry contents need no reset; INIT rewrites them.
REQ-034 Reset asserted mid-operation SHALL abort all state and restart INIT; no partial allocation may survive.

Verification
REQ-035 Reset release, idle 32 cycles -> ready=1, free_count=32, alloc_preg=32, almost_empty=0.
REQ-036 After INIT, alloc_req held 32 cycles -> IDs 32..63 granted in order, then alloc_gnt=0, free_count=0, alloc_preg=0.
REQ-037 Empty list, alloc_req=1 and rel_valid=1 with rel_preg=5 together -> alloc_gnt=0 that cycle; next cycle alloc_gnt=1 with alloc_preg=5.
REQ-038 Full list: ckpt_save with a grant of 32, then 3 further grants (33,34,35), then flush -> free_count=31, alloc_preg=33.
REQ-039 Full list, rel_valid with rel_preg=7 and no alloc -> dropped, err_overflow=1 and stays 1, free_count=32.
REQ-040 Reset pulsed mid-run with free_count=10 -> outputs take reset values asynchronously; 32 cycles later free_count=32, alloc_preg=32.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// -----------------------------------------------------------------------------
// phys_reg_free_list
//   Free list of physical register IDs for a register-renaming front end.
//   A circular buffer holds the IDs not currently mapped to an architectural
//   register. After reset the list fills itself with IDs NUM_LOG..NUM_PHY-1
//   (one per cycle), then serves one allocation and one release per cycle.
//   A single head-pointer checkpoint supports branch mispredict recovery.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   alloc_req    in   rename requests one free physical register
//   alloc_gnt    out  combinational grant; alloc_preg is consumed when high
//   alloc_preg   out  ID at the list head (0 when the list is empty)
//   rel_valid    in   commit returns one physical register
//   rel_preg     in   ID being returned
//   ckpt_save    in   snapshot the (next-cycle) head pointer
//   flush        in   restore the head pointer from the snapshot
//   ready        out  list initialised and running
//   free_count   out  registered number of free entries
//   almost_empty out  free_count <= 2
//   err_overflow out  sticky: a release was dropped because the list was full
// -----------------------------------------------------------------------------
module phys_reg_free_list #(
  parameter int NUM_LOG  = 32,
  parameter int NUM_PHY  = 64,
  parameter int FL_DEPTH = NUM_PHY - NUM_LOG
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc_req,
  output logic                          alloc_gnt,
  output logic [$clog2(NUM_PHY)-1:0]    alloc_preg,
  input  logic                          rel_valid,
  input  logic [$clog2(NUM_PHY)-1:0]    rel_preg,
  input  logic                          ckpt_save,
  input  logic                          flush,
  output logic                          ready,
  output logic [$clog2(FL_DEPTH):0]     free_count,
  output logic                          almost_empty,
  output logic                          err_overflow
);

  localparam int IDW  = $clog2(NUM_PHY);   // physical register ID width
  localparam int IW   = $clog2(FL_DEPTH);  // buffer index width
  localparam int PTRW = IW + 1;            // pointer width (extra wrap bit)

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   init_cnt, init_cnt_n;
  logic [PTRW-1:0] rd_ptr, rd_ptr_n;
  logic [PTRW-1:0] wr_ptr, wr_ptr_n;
  logic [PTRW-1:0] ckpt_ptr, ckpt_ptr_n;
  logic [PTRW-1:0] count;
  logic            empty, full, run;
  logic            rel_ok, rel_drop;
  logic            we;
  logic [IW-1:0]   waddr;
  logic [IDW-1:0]  wdata;

  logic [IDW-1:0]  entries [FL_DEPTH];

  assign run   = (state == S_RUN);
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == PTRW'(FL_DEPTH));

  // No bypass from release to allocation: an empty list never grants,
  // even when a release arrives in the same cycle.
  assign alloc_gnt  = run & alloc_req & ~empty & ~flush;
  assign alloc_preg = empty ? '0 : entries[rd_ptr[IW-1:0]];

  // A full list can still accept a release when a grant frees the head slot.
  assign rel_ok   = run & rel_valid & (~full | alloc_gnt);
  assign rel_drop = run & rel_valid & full & ~alloc_gnt;

  assign ready        = run;
  assign almost_empty = (free_count <= PTRW'(2));

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    ckpt_ptr_n = ckpt_ptr;
    we         = 1'b0;
    waddr      = wr_ptr[IW-1:0];
    wdata      = rel_preg;

    unique case (state)
      S_INIT: begin
        we         = 1'b1;
        waddr      = init_cnt;
        wdata      = IDW'(NUM_LOG) + IDW'(init_cnt);
        wr_ptr_n   = wr_ptr + 1'b1;
        init_cnt_n = init_cnt + 1'b1;
        if (init_cnt == IW'(FL_DEPTH - 1))
          state_n = S_RUN;
      end

      S_RUN: begin
        if (flush)
          rd_ptr_n = ckpt_ptr;
        else if (alloc_gnt)
          rd_ptr_n = rd_ptr + 1'b1;

        // Snapshot the head as it will be after this edge, so the register
        // granted alongside the branch is not handed back on a flush.
        if (ckpt_save && !flush)
          ckpt_ptr_n = alloc_gnt ? rd_ptr + 1'b1 : rd_ptr;

        if (rel_ok) begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
        end
      end

      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      init_cnt     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      ckpt_ptr     <= '0;
      free_count   <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_n;
      init_cnt     <= init_cnt_n;
      rd_ptr       <= rd_ptr_n;
      wr_ptr       <= wr_ptr_n;
      ckpt_ptr     <= ckpt_ptr_n;
      free_count   <= wr_ptr_n - rd_ptr_n;
      err_overflow <= err_overflow | rel_drop;
    end
  end

  // Contents are not reset; the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (we)
      entries[waddr] <= wdata;
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0;
  logic       alloc_gnt;
  logic [5:0] alloc_preg;
  logic       rel_valid = 1'b0;
  logic [5:0] rel_preg = '0;
  logic       ckpt_save = 1'b0;
  logic       flush = 1'b0;
  logic       ready;
  logic [5:0] free_count;
  logic       almost_empty;
  logic       err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model of the free list
  logic [5:0] m_ring [64];
  logic [5:0] m_rd, m_wr, m_ck;
  logic       m_run, m_err;
  int         m_icnt;

  // scoreboard of expected granted IDs
  logic [5:0] exp_q [$];

  logic       last_gnt;
  logic [5:0] last_preg;

  phys_reg_free_list #(.NUM_LOG(32), .NUM_PHY(64), .FL_DEPTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_preg   (alloc_preg),
    .rel_valid    (rel_valid),
    .rel_preg     (rel_preg),
    .ckpt_save    (ckpt_save),
    .flush        (flush),
    .ready        (ready),
    .free_count   (free_count),
    .almost_empty (almost_empty),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] m_cnt();
    return m_wr - m_rd;
  endfunction

  task automatic model_reset();
    m_rd = '0; m_wr = '0; m_ck = '0;
    m_run = 1'b0; m_err = 1'b0; m_icnt = 0;
    exp_q.delete();
  endtask

  // One cycle: drive at posedge+1, check combinational outputs, clock,
  // check registered outputs at posedge+1.
  task automatic step(input logic a, input logic r, input logic [5:0] rp,
                      input logic ck, input logic fl);
    logic       e_gnt;
    logic [5:0] e_preg, got_id, cnt;
    alloc_req = a; rel_valid = r; rel_preg = rp; ckpt_save = ck; flush = fl;
    cnt    = m_cnt();
    e_gnt  = m_run & a & (cnt != 0) & ~fl;
    e_preg = (cnt != 0) ? m_ring[m_rd] : 6'd0;
    if (e_gnt) exp_q.push_back(m_ring[m_rd]);
    #1;
    last_gnt  = alloc_gnt;
    last_preg = alloc_preg;
    chk("alloc_gnt", int'(alloc_gnt), int'(e_gnt));
    chk("alloc_preg", int'(alloc_preg), int'(e_preg));
    if (alloc_gnt) begin
      if (exp_q.size() == 0) chk("unexpected_grant", 1, 0);
      else begin
        got_id = exp_q.pop_front();
        chk("sb_grant_id", int'(alloc_preg), int'(got_id));
      end
    end
    // model update
    if (!m_run) begin
      m_ring[m_wr] = 6'(32 + m_icnt);
      m_wr++;
      if (m_icnt == 31) m_run = 1'b1;
      m_icnt++;
    end else begin
      if (r) begin
        if (cnt < 32 || e_gnt) begin
          m_ring[m_wr] = rp;
          m_wr++;
        end else m_err = 1'b1;
      end
      if (fl) m_rd = m_ck;
      else begin
        if (ck) m_ck = e_gnt ? m_rd + 6'd1 : m_rd;
        if (e_gnt) m_rd++;
      end
    end
    @(posedge clk);
    #1;
    chk("free_count", int'(free_count), int'(m_cnt()));
    chk("almost_empty", int'(almost_empty), int'(m_cnt() <= 2));
    chk("ready", int'(ready), int'(m_run));
    chk("err_overflow", int'(err_overflow), int'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", int'(ready), 0);
    chk("rst_free_count", int'(free_count), 0);
    chk("rst_alloc_gnt", int'(alloc_gnt), 0);
    chk("rst_err_overflow", int'(err_overflow), 0);
    chk("rst_almost_empty", int'(almost_empty), 1);
  endtask

  initial begin
    // power-on reset
    model_reset();
    #3;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // INIT fills the list: ready after 32 edges
    idle(31);
    chk("ready_before_32", int'(ready), 0);
    idle(1);
    chk("init_ready", int'(ready), 1);
    chk("init_free_count", int'(free_count), 32);
    chk("init_alloc_preg", int'(alloc_preg), 32);
    chk("init_almost_empty", int'(almost_empty), 0);

    // drain: IDs 32..63 in order, then no grant
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      chk("drain_id", int'(last_preg), 32 + i);
    end
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("empty_gnt", int'(last_gnt), 0);
    chk("empty_preg", int'(last_preg), 0);
    chk("empty_free_count", int'(free_count), 0);

    // empty list, alloc + release together: no bypass
    step(1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
    chk("nobypass_gnt", int'(last_gnt), 0);
    chk("nobypass_count", int'(free_count), 1);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("bypass_next_gnt", int'(last_gnt), 1);
    chk("bypass_next_preg", int'(last_preg), 5);

    // refill with 32..63
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 6'(32 + i), 1'b0, 1'b0);
    chk("refill_count", int'(free_count), 32);

    // full list: release with no alloc is dropped, error sticks
    step(1'b0, 1'b1, 6'd7, 1'b0, 1'b0);
    chk("ovf_err", int'(err_overflow), 1);
    chk("ovf_count", int'(free_count), 32);
    idle(2);
    chk("ovf_sticky", int'(err_overflow), 1);

    // full list: release accepted alongside a grant
    step(1'b1, 1'b1, 6'd32, 1'b0, 1'b0);
    chk("full_swap_count", int'(free_count), 32);
    // list head now 33; rotate back so head is 32 for the checkpoint case
    for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 6'(33 + i), 1'b0, 1'b0);
    chk("rotated_head", int'(alloc_preg), 32);

    // checkpoint with grant of 32, three more grants, then flush
    step(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
    chk("ckpt_grant", int'(last_preg), 32);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("flush_count", int'(free_count), 31);
    chk("flush_preg", int'(alloc_preg), 33);
    // flush squashes allocation and a same-cycle checkpoint; release still written
    step(1'b1, 1'b1, 6'd9, 1'b1, 1'b1);
    chk("flush_gnt", int'(last_gnt), 0);
    chk("flush_rel_count", int'(free_count), 32);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("old_ckpt_kept", int'(alloc_preg), 33);

    // random traffic, no flush
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), 1'($urandom_range(0, 7) == 0), 1'b0);

    // bring count to 10, then reset mid-run
    for (int i = 0; i < 64 && m_cnt() > 10; i++) step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 64 && m_cnt() < 10; i++) step(1'b0, 1'b1, 6'd3, 1'b0, 1'b0);
    chk("pre_reset_count", int'(free_count), 10);
    alloc_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(32);
    chk("rerun_ready", int'(ready), 1);
    chk("rerun_free_count", int'(free_count), 32);
    chk("rerun_alloc_preg", int'(alloc_preg), 32);
    chk("sb_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
